// File: rtl/vtg_pkg.sv
// Shared definitions for the raster timing generator: region encoding,
// default 640x480@60 timing and the count-to-region decode.
package vtg_pkg;

   typedef enum logic [1:0] {
      REG_ACTIVE = 2'd0,
      REG_FP     = 2'd1,
      REG_SYNC   = 2'd2,
      REG_BP     = 2'd3
   } region_t;

   localparam int unsigned DEF_H_VA  = 640;
   localparam int unsigned DEF_H_FP  = 16;
   localparam int unsigned DEF_H_SP  = 96;
   localparam int unsigned DEF_H_BP  = 48;
   localparam int unsigned DEF_V_VA  = 480;
   localparam int unsigned DEF_V_FP  = 10;
   localparam int unsigned DEF_V_SP  = 2;
   localparam int unsigned DEF_V_BP  = 33;
   localparam int unsigned DEF_CNT_W = 13;

   // Counts beyond the end of the axis never occur; they decode as active.
   function automatic region_t calcRegion(input int unsigned cnt, input int unsigned va,
                                          input int unsigned fp, input int unsigned sp,
                                          input int unsigned bp);
      region_t r;
      r = REG_ACTIVE;
      if (cnt < va)
         r = REG_ACTIVE;
      else if (cnt < va + fp)
         r = REG_FP;
      else if (cnt < va + fp + sp)
         r = REG_SYNC;
      else if (cnt < va + fp + sp + bp)
         r = REG_BP;
      return r;
   endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: wrapping position counter with terminal-count flag and
// region decode of the current count.
module vtg_axis_counter
   import vtg_pkg::*;
#(
   parameter int unsigned VA    = DEF_H_VA,
   parameter int unsigned FP    = DEF_H_FP,
   parameter int unsigned SP    = DEF_H_SP,
   parameter int unsigned BP    = DEF_H_BP,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iStep,
   output logic [CNT_W-1:0] oCount,
   output logic             oWrap,
   output region_t          oRegion
);

   localparam int unsigned      TOTAL = VA + FP + SP + BP;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge iClk) begin
      if (iRst)
         count <= '0;
      else if (iStep)
         count <= (count == LAST) ? '0 : count + 1'b1;
   end

   assign oCount  = count;
   assign oWrap   = (count == LAST);
   assign oRegion = calcRegion(32'(count), VA, FP, SP, BP);

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with pixel enable and sync polarity.
// Optional frame counter output oFrameCnt when VTG_FRAME_COUNTER_EN is defined.
module video_timing_gen
   import vtg_pkg::*;
#(
   parameter int unsigned H_VA   = DEF_H_VA,
   parameter int unsigned H_FP   = DEF_H_FP,
   parameter int unsigned H_SP   = DEF_H_SP,
   parameter int unsigned H_BP   = DEF_H_BP,
   parameter int unsigned V_VA   = DEF_V_VA,
   parameter int unsigned V_FP   = DEF_V_FP,
   parameter int unsigned V_SP   = DEF_V_SP,
   parameter int unsigned V_BP   = DEF_V_BP,
   parameter bit          HS_POL = 1'b0,
   parameter bit          VS_POL = 1'b0,
   parameter int unsigned CNT_W  = DEF_CNT_W
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iCe,
   output logic             oDE,
   output logic             oHS,
   output logic             oVS,
   output logic [CNT_W-1:0] oX,
   output logic [CNT_W-1:0] oY,
   output logic             oLineStart,
   output logic             oFrameStart
`ifdef VTG_FRAME_COUNTER_EN
   ,
   output logic [15:0]      oFrameCnt
`endif
);

   localparam int unsigned H_TOTAL = H_VA + H_FP + H_SP + H_BP;
   localparam int unsigned V_TOTAL = V_VA + V_FP + V_SP + V_BP;

   if (H_VA == 0 || H_FP == 0 || H_SP == 0 || H_BP == 0 ||
       V_VA == 0 || V_FP == 0 || V_SP == 0 || V_BP == 0 ||
       ((H_TOTAL - 1) >> CNT_W) != 0 || ((V_TOTAL - 1) >> CNT_W) != 0) begin : gCfgErr
      $error("video_timing_gen: invalid timing parameters or CNT_W too small");
   end

   logic [CNT_W-1:0] hCnt, vCnt;
   logic             hWrap;
   region_t          hReg, vReg;

   vtg_axis_counter #(.VA(H_VA), .FP(H_FP), .SP(H_SP), .BP(H_BP), .CNT_W(CNT_W)) hAxis (
      .iClk(iClk), .iRst(iRst), .iStep(iCe),
      .oCount(hCnt), .oWrap(hWrap), .oRegion(hReg)
   );

`ifdef VTG_FRAME_COUNTER_EN
   logic vWrap;
`endif

   vtg_axis_counter #(.VA(V_VA), .FP(V_FP), .SP(V_SP), .BP(V_BP), .CNT_W(CNT_W)) vAxis (
      .iClk(iClk), .iRst(iRst), .iStep(hWrap && iCe),
      .oCount(vCnt),
`ifdef VTG_FRAME_COUNTER_EN
      .oWrap(vWrap),
`else
      .oWrap(),
`endif
      .oRegion(vReg)
   );

   always_ff @(posedge iClk) begin
      if (iRst) begin
         oDE         <= 1'b0;
         oHS         <= ~HS_POL;
         oVS         <= ~VS_POL;
         oX          <= '0;
         oY          <= '0;
         oLineStart  <= 1'b0;
         oFrameStart <= 1'b0;
      end else if (iCe) begin
         oDE         <= (hReg == REG_ACTIVE) && (vReg == REG_ACTIVE);
         oHS         <= (hReg == REG_SYNC) ? HS_POL : ~HS_POL;
         oVS         <= (vReg == REG_SYNC) ? VS_POL : ~VS_POL;
         oX          <= hCnt;
         oY          <= vCnt;
         oLineStart  <= (hCnt == '0);
         oFrameStart <= (hCnt == '0) && (vCnt == '0);
      end
   end

`ifdef VTG_FRAME_COUNTER_EN
   // Internal count steps on the frame wrap; the registered copy therefore
   // changes together with the oFrameStart pulse of the new frame.
   logic [15:0] frameCnt;

   always_ff @(posedge iClk) begin
      if (iRst) begin
         frameCnt  <= '0;
         oFrameCnt <= '0;
      end else if (iCe) begin
         oFrameCnt <= frameCnt;
         if (hWrap && vWrap)
            frameCnt <= frameCnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three configurations share clock, enable and
// reset and are checked against a pixel-index reference model.
module tb_video_timing_gen;

   localparam int unsigned HVA[3] = '{640, 640, 4};
   localparam int unsigned HFP[3] = '{16, 16, 1};
   localparam int unsigned HSP[3] = '{96, 96, 1};
   localparam int unsigned HBP[3] = '{48, 48, 1};
   localparam int unsigned VVA[3] = '{480, 12, 2};
   localparam int unsigned VFP[3] = '{10, 2, 1};
   localparam int unsigned VSP[3] = '{2, 2, 1};
   localparam int unsigned VBP[3] = '{33, 3, 1};
   localparam bit          HPOL[3] = '{1'b0, 1'b0, 1'b1};
   localparam bit          VPOL[3] = '{1'b0, 1'b0, 1'b1};

   logic        iClk, iRst, iCe;
   logic        de[3], hs[3], vs[3], ls[3], fs[3];
   logic [12:0] x[3], y[3];
`ifdef VTG_FRAME_COUNTER_EN
   logic [15:0] fc[3];
`endif

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned nEn = 0;   // enabled edges since the last reset edge

   for (genvar g = 0; g < 3; g++) begin : gDut
      video_timing_gen #(
         .H_VA(HVA[g]), .H_FP(HFP[g]), .H_SP(HSP[g]), .H_BP(HBP[g]),
         .V_VA(VVA[g]), .V_FP(VFP[g]), .V_SP(VSP[g]), .V_BP(VBP[g]),
         .HS_POL(HPOL[g]), .VS_POL(VPOL[g]), .CNT_W(13)
      ) dut (
         .iClk(iClk), .iRst(iRst), .iCe(iCe),
         .oDE(de[g]), .oHS(hs[g]), .oVS(vs[g]), .oX(x[g]), .oY(y[g]),
         .oLineStart(ls[g]), .oFrameStart(fs[g])
`ifdef VTG_FRAME_COUNTER_EN
         , .oFrameCnt(fc[g])
`endif
      );
   end

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // Expected outputs after n enabled edges: pixel p = n-1 of a linear frame.
   function automatic logic [46:0] expVec(int m, int unsigned n);
      int unsigned ht, vt, p, px, py, hs0, vs0;
      logic hsv, vsv;
      logic [15:0] f;
      ht = HVA[m] + HFP[m] + HSP[m] + HBP[m];
      vt = VVA[m] + VFP[m] + VSP[m] + VBP[m];
      if (n == 0)
         return {16'd0, 1'b0, ~HPOL[m], ~VPOL[m], 2'b00, 26'd0};
      p   = (n - 1) % (ht * vt);
      px  = p % ht;
      py  = p / ht;
      hs0 = HVA[m] + HFP[m];
      vs0 = VVA[m] + VFP[m];
      hsv = (px >= hs0 && px < hs0 + HSP[m]) ? HPOL[m] : ~HPOL[m];
      vsv = (py >= vs0 && py < vs0 + VSP[m]) ? VPOL[m] : ~VPOL[m];
      f = '0;
`ifdef VTG_FRAME_COUNTER_EN
      f = 16'((n - 1) / (ht * vt));
`endif
      return {f, (px < HVA[m]) && (py < VVA[m]), hsv, vsv, px == 0, p == 0, 13'(px), 13'(py)};
   endfunction

   function automatic logic [46:0] actVec(int m);
      logic [15:0] f;
      f = '0;
`ifdef VTG_FRAME_COUNTER_EN
      f = fc[m];
`endif
      return {f, de[m], hs[m], vs[m], ls[m], fs[m], x[m], y[m]};
   endfunction

   task automatic tick(input logic ce, input logic rst);
      iCe  = ce;
      iRst = rst;
      @(posedge iClk);
      #1;
      if (rst)
         nEn = 0;
      else if (ce)
         nEn++;
   endtask

   task automatic test_reset();
      for (int unsigned i = 0; i < 3; i++) tick(1'b1, 1'b1);
      for (int m = 0; m < 3; m++) begin
         checks++;
         if (actVec(m) !== expVec(m, 0)) begin
            errors++;
            $display("FAIL reset mode%0d act=%h exp=%h", m, actVec(m), expVec(m, 0));
         end
      end
   endtask

   task automatic test_first_edge();
      tick(1'b1, 1'b0);
      for (int m = 0; m < 3; m++) begin
         checks++;
         if ({de[m], ls[m], fs[m], x[m], y[m]} !== {3'b111, 26'd0}) begin
            errors++;
            $display("FAIL first_edge mode%0d act=%h exp=%h", m,
                     {de[m], ls[m], fs[m], x[m], y[m]}, {3'b111, 26'd0});
         end
      end
   endtask

   task automatic test_line();
      int unsigned deCnt = 0, hsLow = 0, lsCnt = 0;
      for (int unsigned i = 0; i < 800; i++) begin
         tick(1'b1, 1'b0);
         for (int m = 0; m < 3; m++) begin
            checks++;
            if (actVec(m) !== expVec(m, nEn)) begin
               errors++;
               $display("FAIL line mode%0d n=%0d act=%h exp=%h", m, nEn, actVec(m), expVec(m, nEn));
            end
         end
         if (de[0]) deCnt++;
         if (!hs[0]) hsLow++;
         if (ls[0]) lsCnt++;
      end
      checks++;
      if (deCnt !== 640) begin errors++; $display("FAIL line_de_count act=%0d exp=640", deCnt); end
      checks++;
      if (hsLow !== 96) begin errors++; $display("FAIL line_hs_count act=%0d exp=96", hsLow); end
      checks++;
      if (lsCnt !== 1) begin errors++; $display("FAIL line_start_count act=%0d exp=1", lsCnt); end
   endtask

   task automatic test_frame();
      int unsigned fs1At = 0, vsLow = 0, badVsEdge = 0, lastFs2 = 0;
      logic prevVs;
      prevVs = vs[1];
      for (int unsigned i = 0; i < 15200; i++) begin
         tick(1'b1, 1'b0);
         for (int m = 0; m < 3; m++) begin
            checks++;
            if (actVec(m) !== expVec(m, nEn)) begin
               errors++;
               if (errors < 20)
                  $display("FAIL frame mode%0d n=%0d act=%h exp=%h", m, nEn, actVec(m), expVec(m, nEn));
            end
         end
         if (fs[1]) fs1At = nEn;
         if (!vs[1]) vsLow++;
         if (vs[1] !== prevVs && x[1] !== 13'd0) badVsEdge++;
         prevVs = vs[1];
         if (fs[2]) begin
            if (lastFs2 != 0) begin
               checks++;
               if (nEn - lastFs2 !== 35) begin
                  errors++;
                  $display("FAIL frame_len_small act=%0d exp=35", nEn - lastFs2);
               end
            end
            lastFs2 = nEn;
         end
      end
      checks++;
      if (fs1At !== 15201) begin errors++; $display("FAIL frame_start_spacing act=%0d exp=15201", fs1At); end
      checks++;
      if (vsLow !== 1600) begin errors++; $display("FAIL vs_low_count act=%0d exp=1600", vsLow); end
      checks++;
      if (badVsEdge !== 0) begin errors++; $display("FAIL vs_edge_align act=%0d exp=0", badVsEdge); end
   endtask

   task automatic test_ce_toggle();
      int unsigned xMoves = 0;
      logic [12:0] prevX;
      prevX = x[0];
      for (int unsigned i = 0; i < 40; i++) begin
         tick((i % 2) == 0, 1'b0);
         for (int m = 0; m < 3; m++) begin
            checks++;
            if (actVec(m) !== expVec(m, nEn)) begin
               errors++;
               $display("FAIL ce_toggle mode%0d n=%0d act=%h exp=%h", m, nEn, actVec(m), expVec(m, nEn));
            end
         end
         if (x[0] !== prevX) xMoves++;
         prevX = x[0];
      end
      checks++;
      if (xMoves !== 20) begin errors++; $display("FAIL ce_toggle_rate act=%0d exp=20", xMoves); end
   endtask

   task automatic test_random();
      for (int unsigned i = 0; i < 3000; i++) begin
         tick(1'($urandom_range(0, 1)), $urandom_range(0, 199) == 0);
         for (int m = 0; m < 3; m++) begin
            checks++;
            if (actVec(m) !== expVec(m, nEn)) begin
               errors++;
               if (errors < 20)
                  $display("FAIL random mode%0d n=%0d act=%h exp=%h", m, nEn, actVec(m), expVec(m, nEn));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      tick(1'b1, 1'b1);
      for (int unsigned i = 0; i < 4301; i++) tick(1'b1, 1'b0);
      checks++;
      if ({x[1], y[1]} !== {13'd300, 13'd5}) begin
         errors++;
         $display("FAIL reset_mid_pos act=%0d,%0d exp=300,5", x[1], y[1]);
      end
      tick(1'b1, 1'b1);
      checks++;
      if ({de[1], hs[1], vs[1], de[2], hs[2], vs[2]} !== 6'b011_000) begin
         errors++;
         $display("FAIL reset_mid_idle act=%b exp=011000", {de[1], hs[1], vs[1], de[2], hs[2], vs[2]});
      end
      tick(1'b1, 1'b0);
      for (int m = 0; m < 3; m++) begin
         checks++;
         if (actVec(m) !== expVec(m, nEn) || fs[m] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_restart mode%0d act=%h exp=%h", m, actVec(m), expVec(m, nEn));
         end
      end
   endtask

   task automatic test_small();
      tick(1'b1, 1'b1);
      for (int unsigned i = 0; i < 71; i++) begin
         tick(1'b1, 1'b0);
         checks++;
         if (hs[2] !== (((nEn - 1) % 7) == 5) || ls[2] !== (((nEn - 1) % 7) == 0)) begin
            errors++;
            $display("FAIL small_line n=%0d act=%b%b exp=%b%b", nEn, hs[2], ls[2],
                     ((nEn - 1) % 7) == 5, ((nEn - 1) % 7) == 0);
         end
`ifdef VTG_FRAME_COUNTER_EN
         checks++;
         if (fc[2] !== 16'((nEn - 1) / 35)) begin
            errors++;
            $display("FAIL small_frame_cnt n=%0d act=%0d exp=%0d", nEn, fc[2], (nEn - 1) / 35);
         end
`endif
      end
   endtask

   initial begin
      iCe  = 1'b0;
      iRst = 1'b1;
      test_reset();
      test_first_edge();
      test_line();
      test_frame();
      test_ce_toggle();
      test_random();
      test_reset_mid();
      test_small();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
